// File: rtl/dw_window_gen_pkg.sv
// Shared constants and helpers for the 3x3 depthwise window generator.
package dw_window_gen_pkg;

    localparam int DEF_ACT_W = 16;
    localparam int KDIM      = 3;
    localparam int KTAPS     = KDIM * KDIM;

    // Tap position inside one channel's window: row i (0 = top), column j (0 = left).
    function automatic int tap_idx(input int i, input int j);
        return KDIM * i + j;
    endfunction

endpackage

// File: rtl/dw_window_gen_if.sv
// Pixel-in / window-out bus of the window generator.
interface dw_window_gen_if
    import dw_window_gen_pkg::*;
#(
    parameter int CH    = 16,
    parameter int ACT_W = DEF_ACT_W
);

    logic                        valid;
    logic                        frame_start;
    logic [CH*ACT_W-1:0]         input_act;
    logic [CH*KTAPS*ACT_W-1:0]   output_act;
    logic                        ready;

    modport master (
        output valid,
        output frame_start,
        output input_act,
        input  output_act,
        input  ready
    );

    modport slave (
        input  valid,
        input  frame_start,
        input  input_act,
        output output_act,
        output ready
    );

endinterface

// File: rtl/dw_window_gen_line_buffer.sv
// One image row of pixels: combinational read and registered write at the
// same address, so a read in the accepting cycle returns the previous row.
module dw_line_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Row storage is not reset; stale entries are never used because emission waits for row 2.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/dw_window_gen.sv
// Streaming 3x3 sliding-window generator: two row buffers, a per-channel
// 3x3 shift window and a registered output word with a one-cycle ready pulse.
module dw_window_gen
    import dw_window_gen_pkg::*;
#(
    parameter int CH     = 16,
    parameter int ACT_W  = DEF_ACT_W,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int STRIDE = 1
) (
    input  logic            clk,
    input  logic            rstn,
    dw_window_gen_if.slave  bus
);

    localparam int PIX_W = CH * ACT_W;
    localparam int WIN_W = CH * KTAPS * ACT_W;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    if ((STRIDE != 1) && (STRIDE != 2)) begin : g_bad_stride
        $error("dw_window_gen: STRIDE must be 1 or 2");
    end

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_eff;
    logic [ROW_W-1:0] row_eff;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_next;
    logic [WIN_W-1:0] out_q;
    logic             ready_q;
    logic             emit;

    dw_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (bus.valid),
        .addr    (col_eff),
        .wr_data (bus.input_act),
        .rd_data (lb1_rd)
    );

    dw_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk     (clk),
        .wr_en   (bus.valid),
        .addr    (col_eff),
        .wr_data (lb1_rd),
        .rd_data (lb0_rd)
    );

    // Position of the current pixel (frame_start forces (0,0)) and whether it completes an emitted window.
    always_comb begin
        col_eff = bus.frame_start ? '0 : col_q;
        row_eff = bus.frame_start ? '0 : row_q;
        emit    = (row_eff >= ROW_TWO) && (col_eff >= COL_TWO)
                  && ((STRIDE == 1) || !row_eff[0])
                  && ((STRIDE == 1) || !col_eff[0]);
    end

    // Shift every channel's window one column left and insert the new column on the right.
    always_comb begin
        win_next = win_q;
        for (int ch = 0; ch < CH; ch++) begin
            for (int i = 0; i < KDIM; i++) begin
                for (int j = 0; j < KDIM - 1; j++) begin
                    win_next[(ch*KTAPS + tap_idx(i, j))*ACT_W +: ACT_W] =
                        win_q[(ch*KTAPS + tap_idx(i, j + 1))*ACT_W +: ACT_W];
                end
            end
            win_next[(ch*KTAPS + tap_idx(0, 2))*ACT_W +: ACT_W] = lb0_rd[ch*ACT_W +: ACT_W];
            win_next[(ch*KTAPS + tap_idx(1, 2))*ACT_W +: ACT_W] = lb1_rd[ch*ACT_W +: ACT_W];
            win_next[(ch*KTAPS + tap_idx(2, 2))*ACT_W +: ACT_W] = bus.input_act[ch*ACT_W +: ACT_W];
        end
    end

    // Raster position counters, advanced once per accepted pixel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q <= '0;
            row_q <= '0;
        end else if (bus.valid) begin
            if (col_eff == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
            end else begin
                col_q <= col_eff + 1'b1;
                row_q <= row_eff;
            end
        end
    end

    // Window shift register, output capture and the one-cycle ready pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_q   <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= bus.valid && emit;
            if (bus.valid) begin
                win_q <= win_next;
                if (emit) begin
                    out_q <= win_next;
                end
            end
        end
    end

    assign bus.output_act = out_q;
    assign bus.ready      = ready_q;

endmodule

// File: tb/tb_dw_window_gen.sv
// Scoreboard bench for dw_window_gen: one 4x4 stride-1 instance and one 6x6
// stride-2 instance, both 16 channels, checked against an image-array model.
module tb_dw_window_gen;

    localparam int CH    = 16;
    localparam int ACT_W = 16;
    localparam int PW    = CH * ACT_W;
    localparam int WW    = CH * 9 * ACT_W;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    dw_window_gen_if #(.CH(CH), .ACT_W(ACT_W)) bus_a ();
    dw_window_gen_if #(.CH(CH), .ACT_W(ACT_W)) bus_b ();

    dw_window_gen #(.CH(CH), .ACT_W(ACT_W), .IMG_W(4), .IMG_H(4), .STRIDE(1)) dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_a)
    );

    dw_window_gen #(.CH(CH), .ACT_W(ACT_W), .IMG_W(6), .IMG_H(6), .STRIDE(2)) dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_b)
    );

    typedef struct {
        int            due;
        logic [WW-1:0] win;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int gw[2] = '{4, 6};
    int gh[2] = '{4, 6};
    int gs[2] = '{1, 2};

    logic [ACT_W-1:0] img [2][CH][6][6];
    int               mr[2];
    int               mc[2];
    int               cyc = 0;
    int               n_tests = 0;
    int               n_fail = 0;
    int               win_count[2];
    logic             vprev_a = 1'b0;
    logic             vprev_b = 1'b0;
    logic [WW-1:0]    last_out[2];
    logic [WW-1:0]    first_win[2];
    logic [WW-1:0]    last_win[2];

    int t2_first[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int t2_last[9]  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

    function automatic logic [ACT_W-1:0] tapOf(input logic [WW-1:0] w, input int ch, input int k);
        return w[ch*9*ACT_W + k*ACT_W +: ACT_W];
    endfunction

    function automatic logic [PW-1:0] patPix(input int d, input int r, input int c, input int base);
        logic [PW-1:0] px;
        for (int ch = 0; ch < CH; ch++) begin
            px[ch*ACT_W +: ACT_W] = ACT_W'(256*ch + gw[d]*r + c + base);
        end
        return px;
    endfunction

    // Cycle counter and the valid that each rising edge actually accepted.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        vprev_a <= bus_a.valid;
        vprev_b <= bus_b.valid;
    end

    // Drive one cycle on DUT d and, for an accepted pixel, record it and queue any window it completes.
    task automatic applyStimulus(input int d, input logic vld, input logic fs, input logic [PW-1:0] px);
        exp_t e;
        int   r;
        int   c;
        @(negedge clk);
        bus_a.valid       = (d == 0) ? vld : 1'b0;
        bus_a.frame_start = (d == 0) ? fs  : 1'b0;
        bus_a.input_act   = px;
        bus_b.valid       = (d == 1) ? vld : 1'b0;
        bus_b.frame_start = (d == 1) ? fs  : 1'b0;
        bus_b.input_act   = px;
        if (vld) begin
            if (fs) begin
                mr[d] = 0;
                mc[d] = 0;
            end
            r = mr[d];
            c = mc[d];
            for (int ch = 0; ch < CH; ch++) img[d][ch][r][c] = px[ch*ACT_W +: ACT_W];
            if (r >= 2 && c >= 2 && ((r - 2) % gs[d]) == 0 && ((c - 2) % gs[d]) == 0) begin
                e.due = cyc + 1;
                e.win = '0;
                for (int ch = 0; ch < CH; ch++)
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            e.win[ch*9*ACT_W + (3*i + j)*ACT_W +: ACT_W] = img[d][ch][r-2+i][c-2+j];
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
            mc[d]++;
            if (mc[d] == gw[d]) begin
                mc[d] = 0;
                mr[d]++;
                if (mr[d] == gh[d]) mr[d] = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 1'b0, 1'b0, '0);
    endtask

    task automatic sendFrame(input int d, input bit gaps, input int base);
        for (int r = 0; r < gh[d]; r++) begin
            for (int c = 0; c < gw[d]; c++) begin
                if (gaps && $urandom_range(1, 0) == 1) idle(1);
                applyStimulus(d, 1'b1, (r == 0 && c == 0), patPix(d, r, c, base));
            end
        end
    endtask

    task automatic sendRandFrame(input int d);
        logic [PW-1:0] px;
        for (int p = 0; p < gw[d]*gh[d]; p++) begin
            for (int ch = 0; ch < CH; ch++) px[ch*ACT_W +: ACT_W] = ACT_W'($urandom);
            if ($urandom_range(1, 0) == 1) idle(1);
            applyStimulus(d, 1'b1, (p == 0), px);
        end
    endtask

    task automatic checkScalar(input string name, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic checkTaps(input string name, input logic [WW-1:0] w, input int expv[9]);
        int bad_ch;
        int bad_k;
        bad_ch = -1;
        bad_k  = 0;
        n_tests++;
        for (int ch = 0; ch < CH; ch++)
            for (int k = 0; k < 9; k++)
                if (bad_ch < 0 && tapOf(w, ch, k) != ACT_W'(expv[k] + 256*ch)) begin
                    bad_ch = ch;
                    bad_k  = k;
                end
        if (bad_ch >= 0) begin
            n_fail++;
            $display("[TB] FAIL %s: lane %0d tap %0d got %0d, expected %0d", name, bad_ch, bad_k,
                     tapOf(w, bad_ch, bad_k), expv[bad_k] + 256*bad_ch);
        end
    endtask

    // Scoreboard side for DUT d: match each ready pulse against the queue, check hold between pulses.
    task automatic checkOutput(input int d, input logic rdy, input logic [WW-1:0] act, input logic pv);
        exp_t e;
        bit   have;
        int   bad_ch;
        int   bad_k;
        if (!rstn) begin
            last_out[d] = '0;
            return;
        end
        if (rdy) begin
            n_tests++;
            if (!pv) begin
                n_fail++;
                $display("[TB] FAIL ready_after_idle dut%0d: ready 1 at cycle %0d, expected 0", d, cyc);
            end
            have = 1'b0;
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            n_tests++;
            if (!have) begin
                n_fail++;
                $display("[TB] FAIL unexpected_window dut%0d: ready 1 at cycle %0d, expected 0", d, cyc);
            end else begin
                if (e.due != cyc) begin
                    n_fail++;
                    $display("[TB] FAIL window_timing dut%0d: ready at cycle %0d, expected %0d", d, cyc, e.due);
                end else if (e.win !== act) begin
                    bad_ch = 0;
                    bad_k  = 0;
                    for (int ch = CH - 1; ch >= 0; ch--)
                        for (int k = 8; k >= 0; k--)
                            if (tapOf(act, ch, k) !== tapOf(e.win, ch, k)) begin
                                bad_ch = ch;
                                bad_k  = k;
                            end
                    n_fail++;
                    $display("[TB] FAIL window_data dut%0d: lane %0d tap %0d got %0d, expected %0d", d, bad_ch,
                             bad_k, tapOf(act, bad_ch, bad_k), tapOf(e.win, bad_ch, bad_k));
                end
            end
            if (win_count[d] == 0) first_win[d] = act;
            last_win[d] = act;
            win_count[d]++;
            last_out[d] = act;
        end else begin
            n_tests++;
            if (act !== last_out[d]) begin
                n_fail++;
                $display("[TB] FAIL output_hold dut%0d: output changed at cycle %0d without ready, expected held", d, cyc);
                last_out[d] = act;
            end
            if (d == 0 && q0.size() > 0 && q0[0].due < cyc) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL missing_window dut%0d: no ready at cycle %0d, expected 1", d, q0[0].due);
                void'(q0.pop_front());
            end
            if (d == 1 && q1.size() > 0 && q1[0].due < cyc) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL missing_window dut%0d: no ready at cycle %0d, expected 1", d, q1[0].due);
                void'(q1.pop_front());
            end
        end
    endtask

    // Monitor: sample both DUTs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        checkOutput(0, bus_a.ready, bus_a.output_act, vprev_a);
        checkOutput(1, bus_b.ready, bus_b.output_act, vprev_b);
    end

    initial begin
        bus_a.valid       = 1'b0;
        bus_a.frame_start = 1'b0;
        bus_a.input_act   = '0;
        bus_b.valid       = 1'b0;
        bus_b.frame_start = 1'b0;
        bus_b.input_act   = '0;
        mr          = '{0, 0};
        mc          = '{0, 0};
        win_count   = '{0, 0};
        last_out[0] = '0;
        last_out[1] = '0;
        first_win[0] = '0;
        first_win[1] = '0;
        last_win[0]  = '0;
        last_win[1]  = '0;

        // Reset held, then released with valid low
        repeat (3) @(negedge clk);
        checkScalar("rst_ready_a", int'(bus_a.ready), 0);
        checkScalar("rst_out_a", int'(|bus_a.output_act), 0);
        checkScalar("rst_ready_b", int'(bus_b.ready), 0);
        checkScalar("rst_out_b", int'(|bus_b.output_act), 0);
        @(posedge clk);
        #2 rstn = 1'b1;
        repeat (5) begin
            idle(1);
            checkScalar("idle_ready_a", int'(bus_a.ready), 0);
            checkScalar("idle_out_a", int'(|bus_a.output_act), 0);
            checkScalar("idle_ready_b", int'(bus_b.ready), 0);
        end

        // Back-to-back 4x4 frame
        win_count[0] = 0;
        sendFrame(0, 1'b0, 0);
        idle(3);
        checkScalar("t2_count", win_count[0], 4);
        checkTaps("t2_first", first_win[0], t2_first);
        checkTaps("t2_last", last_win[0], t2_last);

        // Same frame with random valid gaps
        win_count[0] = 0;
        sendFrame(0, 1'b1, 0);
        idle(3);
        checkScalar("t3_count", win_count[0], 4);
        checkTaps("t3_first", first_win[0], t2_first);
        checkTaps("t3_last", last_win[0], t2_last);

        // 6x6 stride 2, centres (1,1) .. (3,3)
        win_count[1] = 0;
        sendFrame(1, 1'b0, 0);
        idle(3);
        checkScalar("t4_count", win_count[1], 4);
        checkScalar("t4_first_centre", int'(tapOf(first_win[1], 0, 4)), 6*1 + 1);
        checkScalar("t4_last_centre", int'(tapOf(last_win[1], 0, 4)), 6*3 + 3);
        win_count[1] = 0;
        sendFrame(1, 1'b1, 0);
        idle(3);
        checkScalar("t4_gap_count", win_count[1], 4);

        // Restart at pixel 7 of a frame carrying different data
        win_count[0] = 0;
        for (int p = 0; p < 7; p++) applyStimulus(0, 1'b1, (p == 0), patPix(0, p / 4, p % 4, 1000));
        sendFrame(0, 1'b0, 0);
        idle(3);
        checkScalar("t5_count", win_count[0], 4);
        checkTaps("t5_first", first_win[0], t2_first);
        checkTaps("t5_last", last_win[0], t2_last);

        // Late restart after the old frame already emitted two windows
        win_count[0] = 0;
        for (int p = 0; p < 14; p++) applyStimulus(0, 1'b1, (p == 0), patPix(0, p / 4, p % 4, 500));
        sendFrame(0, 1'b1, 0);
        idle(3);
        checkScalar("t5_late_count", win_count[0], 6);
        checkTaps("t5_late_last", last_win[0], t2_last);

        // Async reset pulse mid-frame, then a full frame on every lane
        for (int p = 0; p < 9; p++) applyStimulus(0, 1'b1, (p == 0), patPix(0, p / 4, p % 4, 300));
        for (int p = 0; p < 20; p++) applyStimulus(1, 1'b1, (p == 0), patPix(1, p / 6, p % 6, 300));
        idle(3);
        @(posedge clk);
        #2 rstn = 1'b0;
        mr = '{0, 0};
        mc = '{0, 0};
        @(posedge clk);
        #2 rstn = 1'b1;
        checkScalar("t6_rst_out_a", int'(|bus_a.output_act), 0);
        win_count[0] = 0;
        sendFrame(0, 1'b0, 0);
        idle(3);
        checkScalar("t6_count", win_count[0], 4);
        checkTaps("t6_first", first_win[0], t2_first);
        checkTaps("t6_last", last_win[0], t2_last);

        // Random data frames on both instances
        for (int f = 0; f < 2; f++) begin
            win_count = '{0, 0};
            sendRandFrame(0);
            sendRandFrame(1);
            idle(3);
            checkScalar("rand_count_a", win_count[0], 4);
            checkScalar("rand_count_b", win_count[1], 4);
        end

        idle(3);
        checkScalar("queue_empty_a", q0.size(), 0);
        checkScalar("queue_empty_b", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
